// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-side bundle between pipeline control and the hazard scoreboard
//
// Purpose: groups the decode-stage operand/destination fields, the pipeline
// hold/flush controls and the scoreboard's stall/forward/counter results.
// Ports (signals):
//   id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_rd_wr,
//   id_is_load, pipe_hold, flush       : driven by pipeline control (master)
//   stall, fwd_rs1, fwd_rs2, stall_cnt : driven by the scoreboard (slave)
interface hazard_scoreboard_if #(
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = 32
);
    localparam int FW = $clog2(PIPE_DEPTH + 1);

    logic             id_valid;
    logic [4:0]       id_rs1;
    logic             id_rs1_used;
    logic [4:0]       id_rs2;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_rd_wr;
    logic             id_is_load;
    logic             pipe_hold;
    logic             flush;
    logic             stall;
    logic [FW-1:0]    fwd_rs1;
    logic [FW-1:0]    fwd_rs2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_wr, id_is_load, pipe_hold, flush,
        input  stall, fwd_rs1, fwd_rs2, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_wr, id_is_load, pipe_hold, flush,
        output stall, fwd_rs1, fwd_rs2, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - tracked-scoreboard hazard unit for the ID stage
//
// Purpose: shifts {valid, rd, is_load} for each in-flight instruction from EX
// (entry 0) to WB (entry PIPE_DEPTH-1), matches the ID sources against it and
// produces the ID stall, forwarding selects and a saturating stall counter.
// Optional feature macro: HC_FORWARD_EN (forwarding; stall only on load-use).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : hazard_scoreboard_if.slave (ID fields, hold/flush in; stall, fwd, count out)
module hazard_scoreboard #(
    parameter int PIPE_DEPTH   = 4,
    parameter int FLUSH_STAGES = 1,
    parameter int LOAD_LAT     = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_scoreboard_if.slave    bus
);
    localparam int FW = $clog2(PIPE_DEPTH + 1);

    logic [PIPE_DEPTH-1:0]      valid_q, valid_d;
    logic [PIPE_DEPTH-1:0]      load_q,  load_d;
    logic [PIPE_DEPTH-1:0][4:0] rd_q,    rd_d;
    logic [CNT_W-1:0]           cnt_q,   cnt_d;

    logic [PIPE_DEPTH-1:0] m1, m2;
    logic                  haz;
    logic                  stall;
    logic [FW-1:0]         fwd1, fwd2;
    logic                  push;

    // x0 never matches; an unused or invalid ID source never matches.
    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            m1[i] = valid_q[i] && (rd_q[i] != 5'd0) && (rd_q[i] == bus.id_rs1)
                    && bus.id_rs1_used && bus.id_valid;
            m2[i] = valid_q[i] && (rd_q[i] != 5'd0) && (rd_q[i] == bus.id_rs2)
                    && bus.id_rs2_used && bus.id_valid;
        end
    end

`ifdef HC_FORWARD_EN
    logic          hit1, hit2, ld1, ld2;
    logic [FW-1:0] idx1, idx2;

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        hit1 = 1'b0; idx1 = '0; ld1 = 1'b0;
        hit2 = 1'b0; idx2 = '0; ld2 = 1'b0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            if (m1[i]) begin
                hit1 = 1'b1; idx1 = i[FW-1:0]; ld1 = load_q[i];
            end
            if (m2[i]) begin
                hit2 = 1'b1; idx2 = i[FW-1:0]; ld2 = load_q[i];
            end
        end
        // Only a load whose data is not yet available forces a stall.
        haz = (hit1 && ld1 && (int'(idx1) < LOAD_LAT))
           || (hit2 && ld2 && (int'(idx2) < LOAD_LAT));
        fwd1 = '0;
        fwd2 = '0;
        if (!bus.flush && !haz) begin
            fwd1 = hit1 ? idx1 + FW'(1) : '0;
            fwd2 = hit2 ? idx2 + FW'(1) : '0;
        end
    end
`else
    logic unused_cfg;

    assign haz  = (|m1) || (|m2);
    assign fwd1 = '0;
    assign fwd2 = '0;
    // The load flag is still tracked so the port-level behaviour is identical.
    assign unused_cfg = (^load_q) ^ (LOAD_LAT > 0);
`endif

    assign stall = haz && !bus.flush;
    assign push  = bus.id_valid && !stall && !bus.flush && bus.id_rd_wr
                   && (bus.id_rd != 5'd0);

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        load_d  = load_q;
        cnt_d   = cnt_q;
        if (!bus.pipe_hold) begin
            valid_d[0] = push;
            rd_d[0]    = push ? bus.id_rd : 5'd0;
            load_d[0]  = push && bus.id_is_load;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                // Instructions younger than the resolving branch become bubbles.
                if (bus.flush && (i <= FLUSH_STAGES)) begin
                    valid_d[i] = 1'b0;
                    rd_d[i]    = 5'd0;
                    load_d[i]  = 1'b0;
                end else begin
                    valid_d[i] = valid_q[i-1];
                    rd_d[i]    = rd_q[i-1];
                    load_d[i]  = load_q[i-1];
                end
            end
            if (stall && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + 1'b1;
        end else if (bus.flush) begin
            // Held pipeline: kill the young stages where they sit.
            for (int i = 0; i < FLUSH_STAGES; i++) begin
                valid_d[i] = 1'b0;
                rd_d[i]    = 5'd0;
                load_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rd_q    <= '0;
            load_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.fwd_rs1   = fwd1;
    assign bus.fwd_rs2   = fwd2;
    assign bus.stall_cnt = cnt_q;
endmodule
